sync_fifo: RTL
==============

# sync_fifo

Single-clock, parametrised FIFO for buffering streams inside one clock domain. It reuses the valid/ready write handshake and valid/ack read handshake of the clock-crossing FIFO. It adds a show-ahead registered read port with full back-to-back throughput, an occupancy count, almost-full/almost-empty flags and a synchronous flush. It sits between same-clock producers and consumers, for example bridge command queues and video line buffers.

## Interface
- address_width, default 4: log2 of entry count; num_entries = 1 << address_width; minimum 1.
- data_width, default 32: entry width in bits.
- almost_full_level, default 12: almost_full asserts when level >= this; legal range 1..num_entries.
- almost_empty_level, default 2: almost_empty asserts when level <= this; legal range 0..num_entries-1.
- clk  input  1  sole clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous, active-high; empties the FIFO.
- write_data  input  data_width  data to push.
- write_valid  input  1  push request.
- write_ready  output  1  FIFO can accept; push occurs when write_valid && write_ready.
- read_data  output  data_width  head entry; meaningful only while read_valid.
- read_valid  output  1  read_data holds the head entry.
- read_ack  input  1  pop; takes effect only when read_valid && read_ack.
- level  output  address_width+1  entries currently stored.
- almost_full  output  1  level >= almost_full_level.
- almost_empty  output  1  level <= almost_empty_level.
- high_water  output  address_width+1  maximum level since reset or flush; zero unless SYNC_FIFO_HIGH_WATER_EN is defined.

## Operation
- Pointers write_p and read_p are address_width+1 bits wide. The extra MSB is the wrap bit.
  - Memory addresses use the low address_width bits.
  - All pointer arithmetic is modulo 2^(address_width+1).
- level = write_p - read_p. write_ready = (level != num_entries). Both are combinational from registered pointers.
- Push: mem[write_p] <= write_data, then write_p++.
- Pop: read_p++. The entry is freed only on the ack, never on presentation.
- Read register update on every edge:
  - read_data <= mem[next_read_p], where next_read_p = pop ? read_p+1 : read_p.
  - read_valid <= (next_read_p != write_p), using the pre-push write_p.
- Consequence: an entry written at edge N cannot be presented until edge N+1. This avoids same-edge read/write address collision.
- While read_valid is high and no pop occurs, read_data is stable.
- Simultaneous push and pop: both pointers advance and level is unchanged.
  - Legal when full: write_ready is low, so no push occurs, only the pop.
  - Legal when level == 1: the pop empties the FIFO and read_valid drops for one cycle.
- A push while write_ready is low is dropped; there is no back-pressure beyond write_ready.
- read_ack while read_valid is low is ignored. Consumers may hold read_ack high continuously.
- Flush or reset: write_p, read_p, read_valid and high_water go to 0 on that edge. A push or pop in the same cycle is discarded. Memory contents are not cleared.

## Timing
- Reset values:
  - write_ready = 1, read_valid = 0, level = 0.
  - almost_full = 0 (almost_full_level >= 1).
  - almost_empty = 1.
  - high_water = 0.
  - read_data is undefined.
- Write-to-read latency: push at edge N gives read_valid = 1 after edge N+1.
- Pop throughput: one entry per cycle sustained while level >= 2.
- write_ready, level and flags change in the cycle after the edge that moved a pointer.
- After a pop at edge N, a freed slot is writable from edge N+1.
- After flush at edge N, write_ready = 1 and read_valid = 0 after edge N. The first push is accepted at edge N+1.

## Configuration
- SYNC_FIFO_HIGH_WATER_EN defined:
  - high_water register updates each edge to max(high_water, level after that edge's push/pop).
  - Cleared by reset and flush.
- Macro undefined: high_water is tied to 0 and no register is built.

## Structure
- Package fifo_pkg holds function fifo_level_width(address_width), returning address_width+1. It is shared with the clock-crossing FIFO for level/pointer typing.
- Sub-module sync_fifo_mem: simple dual-port RAM with one write port and one registered read port with read-before-write semantics. It is parametrised by address_width and data_width so the RAM infers as block RAM.
- Pointer, flag, flush and high-water logic live in sync_fifo.

## Test plan
All scenarios use address_width=2, data_width=8, almost_full_level=3, almost_empty_level=1.
- Reset: hold reset_n low for 2 cycles → write_ready=1, read_valid=0, level=0, almost_empty=1, almost_full=0, high_water=0.
- Fill: push 0x11, 0x22, 0x33, 0x44 with read_ack=0.
  - level steps 1..4; almost_full asserts at level 3; write_ready=0 at level 4.
  - A 5th push of 0x55 is dropped.
  - read_data=0x11 is stable.
- Drain: from full, hold read_ack=1 → read_data sequence 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then read_valid=0 and level=0.
- Latency and concurrency:
  - Push 0xA5 into an empty FIFO at edge N → read_valid=1 and read_data=0xA5 after edge N+1.
  - At level 2, push and pop on the same edge → level stays 2 and FIFO order is preserved across pointer wrap for 10 passes.
- Flush: at level 3, assert flush with write_valid=1 → level=0, read_valid=0 next cycle, pushed data never appears.
  - With SYNC_FIFO_HIGH_WATER_EN defined, high_water goes from 3 to 0.
- Reset mid-operation: while streaming, pulse reset_n low for 1 cycle → all outputs return to reset values; subsequent data 0x5A is read first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers.
// Used by sync_fifo and by the clock-crossing FIFO to size level and pointer
// signals consistently.
//   fifo_level_width(address_width) : bits needed for a pointer with wrap bit,
//                                      which is also the width of a level count
//                                      that must represent 0..num_entries.
package fifo_pkg;

  function automatic int fifo_level_width(input int address_width);
    return address_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM for sync_fifo: one write port, one registered read port.
// The read and write happen on the same edge with read-before-write behaviour,
// so a read of the address being written returns the old contents.
// Ports:
//   clk         : clock
//   write_en    : write strobe
//   write_addr  : write address
//   write_data  : write data
//   read_addr   : read address, sampled every edge
//   read_data   : registered read data
module sync_fifo_mem #(
  parameter int address_width = 4,
  parameter int data_width    = 32
) (
  input  logic                     clk,
  input  logic                     write_en,
  input  logic [address_width-1:0] write_addr,
  input  logic [data_width-1:0]    write_data,
  input  logic [address_width-1:0] read_addr,
  output logic [data_width-1:0]    read_data
);

  logic [data_width-1:0] mem [1 << address_width];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead registered read port, occupancy count,
// almost-full/almost-empty flags and synchronous flush.
//
// Handshakes:
//   write side: a push happens on an edge where write_valid && write_ready.
//               A write while write_ready is low is dropped.
//   read side:  read_data holds the head entry while read_valid is high; the
//               entry is consumed on an edge where read_valid && read_ack.
//               read_ack while read_valid is low is ignored.
//
// Ports:
//   clk, reset_n (sync, active-low), flush (sync, active-high)
//   write_data, write_valid, write_ready
//   read_data, read_valid, read_ack
//   level        : entries stored (write_p - read_p)
//   almost_full  : level >= almost_full_level
//   almost_empty : level <= almost_empty_level
//   high_water   : max level since reset/flush; only built when the macro
//                  SYNC_FIFO_HIGH_WATER_EN is defined, otherwise tied to 0.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int address_width      = 4,
  parameter int data_width         = 32,
  parameter int almost_full_level  = 12,
  parameter int almost_empty_level = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      flush,
  input  logic [data_width-1:0]                     write_data,
  input  logic                                      write_valid,
  output logic                                      write_ready,
  output logic [data_width-1:0]                     read_data,
  output logic                                      read_valid,
  input  logic                                      read_ack,
  output logic [fifo_level_width(address_width)-1:0] level,
  output logic                                      almost_full,
  output logic                                      almost_empty,
  output logic [fifo_level_width(address_width)-1:0] high_water
);

  localparam int            lw          = fifo_level_width(address_width);
  localparam int            num_entries = 1 << address_width;
  localparam logic [lw-1:0] full_level  = lw'(num_entries);
  localparam logic [lw-1:0] af_level    = lw'(almost_full_level);
  localparam logic [lw-1:0] ae_level    = lw'(almost_empty_level);
  localparam logic [lw-1:0] one         = lw'(1);

  logic [lw-1:0] write_p;
  logic [lw-1:0] read_p;
  logic [lw-1:0] next_read_p;
  logic          push;
  logic          pop;
  logic          clear;

  assign clear       = !reset_n || flush;
  assign level       = write_p - read_p;
  assign write_ready = (level != full_level);
  assign push        = write_valid && write_ready;
  assign pop         = read_valid && read_ack;
  assign next_read_p = pop ? read_p + one : read_p;

  assign almost_full  = (level >= af_level);
  assign almost_empty = (level <= ae_level);

  always_ff @(posedge clk) begin
    if (clear) begin
      write_p <= '0;
    end else if (push) begin
      write_p <= write_p + one;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      read_p <= '0;
    end else if (pop) begin
      read_p <= read_p + one;
    end
  end

  // Compared against the pre-push write_p: an entry written on this edge is
  // not presented until the next one, so the RAM never reads and writes the
  // same address expecting the new data.
  always_ff @(posedge clk) begin
    if (clear) begin
      read_valid <= 1'b0;
    end else begin
      read_valid <= (next_read_p != write_p);
    end
  end

  sync_fifo_mem #(
    .address_width(address_width),
    .data_width   (data_width)
  ) u_mem (
    .clk       (clk),
    .write_en  (push && !clear),
    .write_addr(write_p[address_width-1:0]),
    .write_data(write_data),
    .read_addr (next_read_p[address_width-1:0]),
    .read_data (read_data)
  );

`ifdef SYNC_FIFO_HIGH_WATER_EN
  logic [lw-1:0] next_level;
  logic [lw-1:0] high_water_q;

  always_comb begin
    next_level = level;
    if (push && !pop) begin
      next_level = level + one;
    end else if (pop && !push) begin
      next_level = level - one;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      high_water_q <= '0;
    end else if (next_level > high_water_q) begin
      high_water_q <= next_level;
    end
  end

  assign high_water = high_water_q;
`else
  assign high_water = '0;
`endif

endmodule
